// File: rtl/dwa_dem_selector.sv
`default_nettype none
// ============================================================================
//  Module      : dwa_dem_selector
//  Description : Data-weighted-averaging dynamic element matching selector.
//                Converts a binary quantizer code into a unit-element select
//                vector for a thermometer DAC. A rotating start pointer spreads
//                element usage so that element mismatch is first-order shaped.
//                One registered sample per clock, latency of one cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module dwa_dem_selector #(
    parameter  int CODE_WIDTH   = 3,
    parameter  int NUM_ELEMENTS = (1 << CODE_WIDTH) - 1,
    localparam int PTR_WIDTH    = $clog2(NUM_ELEMENTS)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [CODE_WIDTH-1:0]   code_i,
    input  logic                    code_valid_i,
    input  logic                    dem_en_i,
    input  logic                    ptr_clr_i,
    output logic [NUM_ELEMENTS-1:0] elem_sel_o,
    output logic                    sel_valid_o,
    output logic [PTR_WIDTH-1:0]    ptr_o,
    output logic                    clip_o
);

    // Sum of pointer and element count needs one bit of headroom over the
    // wider of the two operands; it is always below 2*N, so a single
    // conditional subtract brings it back into range.
    localparam int SUM_W = ((PTR_WIDTH > CODE_WIDTH) ? PTR_WIDTH : CODE_WIDTH) + 1;

    localparam logic [CODE_WIDTH-1:0] c_N_CODE = CODE_WIDTH'(NUM_ELEMENTS);
    localparam logic [SUM_W-1:0]      c_N_SUM  = SUM_W'(NUM_ELEMENTS);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PTR_WIDTH-1:0]    r_ptr;
    logic [NUM_ELEMENTS-1:0] r_sel;
    logic                    r_valid;
    logic                    r_clip;

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic                      w_clip;
    logic [CODE_WIDTH-1:0]     w_n;
    logic [PTR_WIDTH-1:0]      w_start;
    logic [SUM_W-1:0]          w_sum;
    logic [SUM_W-1:0]          w_wrap;
    logic [PTR_WIDTH-1:0]      w_ptr_adv;
    logic [NUM_ELEMENTS-1:0]   w_therm;
    logic [2*NUM_ELEMENTS-1:0] w_dbl;
    logic [NUM_ELEMENTS-1:0]   w_rot;
    logic [NUM_ELEMENTS-1:0]   w_sel_nxt;
    logic [PTR_WIDTH-1:0]      w_ptr_nxt;

    // Clamp the code to the number of physical elements and flag overflow.
    always_comb begin
        w_clip = (code_i > c_N_CODE);
        w_n    = w_clip ? c_N_CODE : code_i;
    end

    // A clear request takes effect before the current sample is placed.
    always_comb begin
        w_start = ptr_clr_i ? '0 : r_ptr;
    end

    // Advance the pointer modulo N without a divider.
    always_comb begin
        w_sum     = SUM_W'(w_start) + SUM_W'(w_n);
        w_wrap    = (w_sum >= c_N_SUM) ? (w_sum - c_N_SUM) : w_sum;
        w_ptr_adv = w_wrap[PTR_WIDTH-1:0];
    end

    // Static thermometer pattern: the lowest n elements enabled.
    always_comb begin
        w_therm = '0;
        for (int k = 0; k < NUM_ELEMENTS; k++) begin
            w_therm[k] = (CODE_WIDTH'(k) < w_n);
        end
    end

    // Circular rotation of the thermometer pattern by the start pointer:
    // shift into a double-width vector and fold the overflow back onto bit 0.
    always_comb begin
        w_dbl = {{NUM_ELEMENTS{1'b0}}, w_therm} << w_start;
        w_rot = w_dbl[NUM_ELEMENTS-1:0] | w_dbl[2*NUM_ELEMENTS-1:NUM_ELEMENTS];
    end

    // Choose rotated or bypass pattern; bypass keeps the pointer parked.
    always_comb begin
        w_sel_nxt = w_therm;
        w_ptr_nxt = w_start;
        if (dem_en_i) begin
            w_sel_nxt = w_rot;
            w_ptr_nxt = w_ptr_adv;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------

    // Capture a new sample when valid; otherwise hold the select vector and
    // still honour a standalone pointer clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr   <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_clip  <= 1'b0;
        end else if (code_valid_i) begin
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_valid <= 1'b1;
            r_clip  <= w_clip;
        end else begin
            r_valid <= 1'b0;
            r_clip  <= 1'b0;
            if (ptr_clr_i) begin
                r_ptr <= '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign elem_sel_o  = r_sel;
    assign sel_valid_o = r_valid;
    assign ptr_o       = r_ptr;
    assign clip_o      = r_clip;

endmodule
`default_nettype wire
